pool1_maxpool: RTL and testbench

First max-pooling stage of the CNN accelerator. Sits between the first convolution layer and the pool-1 output FIFO that serially feeds the second convolution layer. Takes the 24x24, 6-channel conv1 feature map as a raster stream, one pixel (all channels) per valid beat. Emits the 12x12 2x2/stride-2 max-pooled map as 144 valid beats per frame, in raster order.

---
 rtl/pool1_maxpool.sv | 109 ++++++++++
 tb/tb_pool1_maxpool.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pool1_maxpool.sv
// First 2x2/stride-2 max-pooling stage: raster stream of CH signed lanes in,
// pooled raster stream out with a fixed one-cycle latency after each (odd,odd) beat.
module pool1_maxpool #(
   parameter int DW   = 16,
   parameter int CH   = 6,
   parameter int IN_W = 24,
   parameter int IN_H = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH*DW-1:0] data_in,
   input  logic             data_in_valid,
   output logic [CH*DW-1:0] data_out,
   output logic             data_out_valid,
   output logic             frame_done
);

   localparam int PW = CH * DW;
   localparam int CW = $clog2(IN_W);
   localparam int RW = $clog2(IN_H);
   localparam int LB = IN_W / 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

   // Per-lane signed maximum; on a tie both operands are identical.
   function automatic logic [PW-1:0] lane_max(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW-1:0] m;
      m = '0;
      for (int k = 0; k < CH; k++) begin
         m[k*DW +: DW] = ($signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW])) ? a[k*DW +: DW]
                                                                           : b[k*DW +: DW];
      end
      return m;
   endfunction

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [PW-1:0] h_reg_q, h_reg_d;
   logic [PW-1:0] line_buf_q [LB];
   logic [PW-1:0] line_buf_d [LB];
   logic [PW-1:0] data_out_q, data_out_d;
   logic          data_out_valid_q, data_out_valid_d;
   logic          frame_done_q, frame_done_d;

   logic [CW-2:0] lb_idx;
   logic [PW-1:0] hmax;
   logic [PW-1:0] vmax;

   assign lb_idx = col_q[CW-1:1];
   assign hmax   = lane_max(h_reg_q, data_in);
   assign vmax   = lane_max(line_buf_q[lb_idx], hmax);

   // Phase comes entirely from (row[0], col[0]); nothing moves without a valid beat.
   always_comb begin
      col_d            = col_q;
      row_d            = row_q;
      h_reg_d          = h_reg_q;
      line_buf_d       = line_buf_q;
      data_out_d       = data_out_q;
      data_out_valid_d = 1'b0;
      frame_done_d     = 1'b0;
      if (data_in_valid) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            h_reg_d = data_in;
         end else if (!row_q[0]) begin
            line_buf_d[lb_idx] = hmax;
         end else begin
            data_out_d       = vmax;
            data_out_valid_d = 1'b1;
            frame_done_d     = (row_q == ROW_LAST) && (col_q == COL_LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q            <= '0;
         row_q            <= '0;
         h_reg_q          <= '0;
         data_out_q       <= '0;
         data_out_valid_q <= 1'b0;
         frame_done_q     <= 1'b0;
         for (int i = 0; i < LB; i++) begin
            line_buf_q[i] <= '0;
         end
      end else begin
         col_q            <= col_d;
         row_q            <= row_d;
         h_reg_q          <= h_reg_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
         frame_done_q     <= frame_done_d;
         for (int i = 0; i < LB; i++) begin
            line_buf_q[i] <= line_buf_d[i];
         end
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = data_out_valid_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_pool1_maxpool.sv
// Directed bench for pool1_maxpool: ramp, signed lanes, gapped input,
// back-to-back frames and mid-frame reset, checked with immediate assertions.
module tb_pool1_maxpool;

   localparam int DW = 16;
   localparam int CH = 6;
   localparam int W  = 24;
   localparam int H  = 24;
   localparam int PW = CH * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic [PW-1:0] data_out;
   logic          data_out_valid;
   logic          frame_done;

   int            checks = 0;
   int            errors = 0;
   int            pulses = 0;
   int            dones = 0;
   logic [PW-1:0] expHold = '0;

   pool1_maxpool #(.DW(DW), .CH(CH), .IN_W(W), .IN_H(H)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] splat(input logic [DW-1:0] v);
      return {CH{v}};
   endfunction

   // One input cycle driven on the falling edge; returns 1 ns after the rising edge.
   task automatic applyStimulus(input logic [PW-1:0] pix, input logic vld);
      @(negedge clk);
      data_in       = pix;
      data_in_valid = vld;
      @(posedge clk);
      #1;
   endtask

   // Compares all outputs; data_out must always equal the last expected pooled value.
   task automatic checkOutput(input string tag, input logic expValid, input logic expDone);
      checks++;
      assert (data_out_valid === expValid) else begin
         errors++;
         $error("[TB] FAIL %s valid: observed=%0b expected=%0b", tag, data_out_valid, expValid);
      end
      checks++;
      assert (frame_done === expDone) else begin
         errors++;
         $error("[TB] FAIL %s frame_done: observed=%0b expected=%0b", tag, frame_done, expDone);
      end
      checks++;
      assert (data_out === expHold) else begin
         errors++;
         $error("[TB] FAIL %s data_out: observed=%h expected=%h", tag, data_out, expHold);
      end
      if (data_out_valid === 1'b1) pulses++;
      if (frame_done === 1'b1) dones++;
   endtask

   task automatic checkCount(input string tag, input int observed, input int expected);
      checks++;
      assert (observed == expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst           = 1'b1;
      data_in_valid = 1'b0;
      data_in       = '0;
      expHold       = '0;
      @(posedge clk);
      #1;
      checkOutput("in_reset", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("after_reset", 1'b0, 1'b0);
   endtask

   // mode 0: value = row*W+col; mode 1: value = 575 - that.
   task automatic sendFrame(input string name, input int mode, input int maxGap, input int nBeats);
      for (int i = 0; i < nBeats; i++) begin
         int r, c, v, g;
         logic pulse;
         r = i / W;
         c = i % W;
         v = r * W + c;
         pulse = (r % 2 == 1) && (c % 2 == 1);
         applyStimulus(splat(mode != 0 ? DW'(W*H-1-v) : DW'(v)), 1'b1);
         if (pulse) expHold = splat(mode != 0 ? DW'(W*H-1-((r-1)*W+c-1)) : DW'(v));
         checkOutput($sformatf("%s r%0d c%0d", name, r, c), pulse, (r == H-1) && (c == W-1));
         if (maxGap > 0) begin
            g = int'($urandom_range(maxGap, 0));
            repeat (g) begin
               applyStimulus('0, 1'b0);
               checkOutput($sformatf("%s gap r%0d c%0d", name, r, c), 1'b0, 1'b0);
            end
         end
      end
   endtask

   logic [DW-1:0] lane0 [4];
   logic [DW-1:0] lane5 [4];

   initial begin
      lane0 = '{16'hFFFB, 16'hFFFD, 16'hFFF9, 16'h8000};
      lane5 = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};

      doReset();

      $display("[TB] continuous ramp frame");
      pulses = 0; dones = 0;
      sendFrame("ramp", 0, 0, W*H);
      checkCount("ramp pulses", pulses, 144);
      checkCount("ramp frame_done", dones, 1);

      $display("[TB] signed lanes");
      doReset();
      for (int i = 0; i < W + 2; i++) begin
         int r, c, p;
         logic [PW-1:0] pix;
         r = i / W;
         c = i % W;
         pix = '0;
         if (c < 2) begin
            p = r * 2 + c;
            pix[0 +: DW]    = lane0[p];
            pix[5*DW +: DW] = lane5[p];
            for (int k = 1; k < 5; k++) pix[k*DW +: DW] = DW'(100 * k + p);
         end
         applyStimulus(pix, 1'b1);
         if (i == W + 1) expHold = {16'h7FFF, 16'd403, 16'd303, 16'd203, 16'd103, 16'hFFFD};
         checkOutput($sformatf("signed r%0d c%0d", r, c), i == W + 1, 1'b0);
      end
      doReset();

      $display("[TB] gapped ramp frame");
      pulses = 0; dones = 0;
      sendFrame("gapped", 0, 5, W*H);
      checkCount("gapped pulses", pulses, 144);
      checkCount("gapped frame_done", dones, 1);

      $display("[TB] back-to-back frames");
      pulses = 0; dones = 0;
      sendFrame("b2b_ramp", 0, 0, W*H);
      sendFrame("b2b_inv", 1, 0, W*H);
      checkCount("b2b pulses", pulses, 288);
      checkCount("b2b frame_done", dones, 2);

      $display("[TB] reset mid-frame");
      sendFrame("partial", 0, 0, 300);
      doReset();
      pulses = 0; dones = 0;
      sendFrame("post_reset", 0, 0, W*H);
      checkCount("post_reset pulses", pulses, 144);
      checkCount("post_reset frame_done", dones, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
